// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//
// Purpose:
//   Filters a raw, bouncy 1-bit input (for example a push button) into a clean
//   registered level. The output moves to a new level only after that level
//   has been sampled on DEBOUNCE_CLKS+1 consecutive clock edges: the edge that
//   first sees it, then DEBOUNCE_CLKS more. A single opposite sample while
//   qualifying throws away all progress. One-cycle edge pulses accompany every
//   change of the debounced level.
//
// Parameters:
//   DEBOUNCE_CLKS  stable clocks required before the output follows (>= 2)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sig_in        in   raw input
//   debounce_out  out  registered debounced level
//   rise_pulse    out  one-cycle pulse when debounce_out goes 0->1
//   fall_pulse    out  one-cycle pulse when debounce_out goes 1->0
//
// Build options:
//   DEBOUNCE_SYNC_EN  when defined, sig_in passes through a 2-flop
//                     synchronizer (reset to 0), adding 2 cycles of latency.
//                     When undefined, sig_in is used directly and must
//                     already be synchronous to clk.
// -----------------------------------------------------------------------------
module debounce #(
  parameter int DEBOUNCE_CLKS = 1200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic debounce_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CLKS);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CLKS - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  // Sample seen by the FSM.
  logic s;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_STAGES = 2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Stage 0 captures the raw input; each later stage captures its predecessor.
  genvar gi;
  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = sig_in;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = sig_in;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      S_WAIT_HIGH: begin
        if (!s) begin
          // Any low sample restarts qualification from scratch.
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (!s) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end

      S_WAIT_LOW: begin
        if (s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = S_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign debounce_out = out_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;

endmodule

// File: tb/tb_debounce.sv
// -----------------------------------------------------------------------------
// tb_debounce
//
// Purpose:
//   Self-checking bench for debounce with DEBOUNCE_CLKS=8. A reference model
//   keeps the recent history of sig_in and declares a level change whenever
//   the last DEBOUNCE_CLKS+1 samples seen by the filter all disagree with the
//   current output. A compare process checks every cycle against that model;
//   directed tests pin the latency and pulse counts with literal values.
// -----------------------------------------------------------------------------
module tb_debounce;

  localparam int N = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif
  // Edges from sig_in first sampled to debounce_out changing.
  localparam int LAT = N + SYNC_DEPTH;
  localparam int H   = SYNC_DEPTH + N + 1;

  logic clk;
  logic rst_n;
  logic sig_in;
  logic debounce_out;
  logic rise_pulse;
  logic fall_pulse;

  debounce #(.DEBOUNCE_CLKS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .debounce_out (debounce_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist_m[0] is the newest sig_in sample. The filter sees sig_in SYNC_DEPTH
  // edges late, so its window is the N+1 samples starting at SYNC_DEPTH.
  logic [H-1:0] hist_m;
  logic [H-1:0] new_hist;
  logic [N:0]   win;
  logic         out_m, rise_m, fall_m;

  assign new_hist = {hist_m[H-2:0], sig_in};
  assign win      = new_hist[SYNC_DEPTH +: N+1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_m <= '0;
      out_m  <= 1'b0;
      rise_m <= 1'b0;
      fall_m <= 1'b0;
    end else begin
      hist_m <= new_hist;
      rise_m <= !out_m && (&win);
      fall_m <= out_m && (win == '0);
      if (!out_m && (&win))
        out_m <= 1'b1;
      else if (out_m && (win == '0))
        out_m <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("debounce_out", {31'd0, debounce_out}, {31'd0, out_m});
        check("rise_pulse",   {31'd0, rise_pulse},   {31'd0, rise_m});
        check("fall_pulse",   {31'd0, fall_pulse},   {31'd0, fall_m});
        check("pulse_overlap", {31'd0, rise_pulse & fall_pulse}, 32'd0);
        if (rise_pulse === 1'b1) rise_cnt++;
        if (fall_pulse === 1'b1) fall_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drives happen 2 time units after a rising edge.
  task automatic drive(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait up to max_edges edges for debounce_out==lvl; k is the 1-based edge
  // index at which it was first seen, or -1 if the bound expired.
  task automatic measure(input logic lvl, input int max_edges, output int k);
    k = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (k < 0 && debounce_out === lvl) k = i;
    end
    #1;
  endtask

  int k;
  int r0, f0;
  logic level;

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("reset_out",  {31'd0, debounce_out}, 32'd0);
    check("reset_rise", {31'd0, rise_pulse},   32'd0);
    check("reset_fall", {31'd0, fall_pulse},   32'd0);
    drive(1'b0, 4);
    $display("reset: out=%0d", debounce_out);

    // Clean rise: first sampled at edge 1, output flips LAT edges later.
    r0 = rise_cnt; f0 = fall_cnt;
    sig_in = 1'b1;
    measure(1'b1, 20, k);
    check("clean_rise_latency", k, LAT + 1);
    drive(1'b1, 5);
    check("clean_rise_pulses", rise_cnt - r0, 32'd1);
    check("clean_rise_nofall", fall_cnt - f0, 32'd0);
    $display("clean rise: edge=%0d", k);

    // Clean fall.
    r0 = rise_cnt; f0 = fall_cnt;
    sig_in = 1'b0;
    measure(1'b0, 20, k);
    check("clean_fall_latency", k, LAT + 1);
    drive(1'b0, 5);
    check("clean_fall_pulses", fall_cnt - f0, 32'd1);
    check("clean_fall_norise", rise_cnt - r0, 32'd0);
    $display("clean fall: edge=%0d", k);

    // Bounce 1,0,1,0 with 3-clock halves, then settle high.
    r0 = rise_cnt;
    drive(1'b1, 3); drive(1'b0, 3); drive(1'b1, 3); drive(1'b0, 3);
    check("bounce_still_low", {31'd0, debounce_out}, 32'd0);
    sig_in = 1'b1;
    measure(1'b1, 20, k);
    check("bounce_latency", k, LAT + 1);
    drive(1'b1, 5);
    check("bounce_pulses", rise_cnt - r0, 32'd1);
    $display("bounce: edge=%0d", k);

    // Glitch of N-1 low clocks while high.
    f0 = fall_cnt;
    drive(1'b0, N - 1);
    drive(1'b1, 20);
    check("glitch_out", {31'd0, debounce_out}, 32'd1);
    check("glitch_nofall", fall_cnt - f0, 32'd0);
    $display("glitch: out=%0d", debounce_out);

    // Reset mid-qualification, then requalify after release.
    drive(1'b0, LAT + 5);
    r0 = rise_cnt;
    drive(1'b1, 5);
    rst_n = 1'b0;
    #1;
    check("midq_reset_out", {31'd0, debounce_out}, 32'd0);
    @(posedge clk);
    #1;
    check("midq_reset_rise", {31'd0, rise_pulse}, 32'd0);
    #1;
    rst_n = 1'b1;
    measure(1'b1, 20, k);
    check("midq_rise_latency", k, LAT + 1);
    drive(1'b1, 5);
    check("midq_pulses", rise_cnt - r0, 32'd1);
    $display("reset mid-qualify: edge=%0d", k);

    // Reset while high forces the output low at once, then rise again.
    rst_n = 1'b0;
    #1;
    check("high_reset_out", {31'd0, debounce_out}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    r0 = rise_cnt;
    measure(1'b1, 20, k);
    check("post_reset_latency", k, LAT + 1);
    drive(1'b1, 5);
    check("post_reset_pulses", rise_cnt - r0, 32'd1);
    $display("reset while high: edge=%0d", k);

    // Random bounce: 200 settled transitions with 1-6 clock bounces.
    r0 = rise_cnt; f0 = fall_cnt;
    level = 1'b1;
    for (int t = 0; t < 200; t++) begin
      int nb;
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        drive(!level, int'($urandom_range(1, 6)));
        drive(level,  int'($urandom_range(1, 6)));
      end
      drive(!level, LAT + 4);
      level = !level;
      check("random_settled", {31'd0, debounce_out}, {31'd0, level});
    end
    check("random_pulse_count", (rise_cnt - r0) + (fall_cnt - f0), 32'd200);
    $display("random: transitions=200 pulses=%0d", (rise_cnt - r0) + (fall_cnt - f0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
